// File: rtl/osc_meas_pkg.sv
// Shared types and helpers for the oscillator frequency meter.
package osc_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StDone
  } meas_state_e;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int unsigned gate_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk and flags its rising edges.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts rising edges of an asynchronous oscillator over a fixed clk gate window,
// with a saturating result and a start/done handshake.
module osc_freq_meter
  import osc_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GateW = gate_cnt_w(GATE_CYCLES);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

  logic edge_det;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (osc_in),
    .rise_pulse (edge_det)
  );

  meas_state_e      state_q, state_d;
  logic [GateW-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          acc_d      = '0;
          acc_ovf_d  = 1'b0;
        end
      end
      StGate: begin
        busy       = 1'b1;
        gate_cnt_d = gate_cnt_q + 1'b1;
        if (edge_det) begin
          if (&acc_q) begin
            acc_ovf_d = 1'b1;
          end else begin
            acc_d = acc_q + 1'b1;
          end
        end
        // Last window cycle: publish the result including this cycle's edge.
        if (gate_cnt_q == GateLast) begin
          state_d = StDone;
          count_d = acc_d;
          ovf_d   = acc_ovf_d;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: a wide-counter DUT and a 4-bit saturating DUT.
module tb_osc_freq_meter;

  localparam int G   = 100;
  localparam int LAT = 3;  // osc change at a negedge is counted SYNC_STAGES+1 posedges later

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        osc_a = 1'b0;
  logic        osc_b = 1'b0;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic        ovf_a, ovf_b, busy_a, busy_b, done_a, done_b;

  osc_freq_meter #(
    .GATE_CYCLES (G),
    .CNT_W       (16),
    .SYNC_STAGES (2)
  ) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .osc_in (osc_a),
    .count  (count_a),
    .ovf    (ovf_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  osc_freq_meter #(
    .GATE_CYCLES (G),
    .CNT_W       (4),
    .SYNC_STAGES (2)
  ) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .osc_in (osc_b),
    .count  (count_b),
    .ovf    (ovf_b),
    .busy   (busy_b),
    .done   (done_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator generators: half == 0 holds the level in hold_*; rises are logged by cycle.
  int   half_a = 0, half_b = 0;
  logic hold_a = 1'b0, hold_b = 1'b0;
  int   ph_a = 0, ph_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   rises_a[$];
  int   rises_b[$];

  always @(negedge clk) begin
    if (half_a == 0) osc_a = hold_a;
    else begin
      ph_a++;
      if (ph_a >= half_a) begin
        ph_a  = 0;
        osc_a = ~osc_a;
      end
    end
    if (osc_a && !prev_a) rises_a.push_back(cyc);
    prev_a = osc_a;
    if (half_b == 0) osc_b = hold_b;
    else begin
      ph_b++;
      if (ph_b >= half_b) begin
        ph_b  = 0;
        osc_b = ~osc_b;
      end
    end
    if (osc_b && !prev_b) rises_b.push_back(cyc);
    prev_b = osc_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rises whose synchronized edge lands inside the gate window of a start driven at cycle s.
  function automatic int model_count(input bit which, input int s);
    int n  = 0;
    int lo = s + 2 - LAT;
    int hi = s + 1 + G - LAT;
    if (which) begin
      foreach (rises_b[i]) if (rises_b[i] >= lo && rises_b[i] <= hi) n++;
    end else begin
      foreach (rises_a[i]) if (rises_a[i] >= lo && rises_a[i] <= hi) n++;
    end
    return n;
  endfunction

  task automatic measure(input bit which, output int got_cnt, output int got_ovf,
                         output int lat, output int busy_n, output int s);
    bit seen = 1'b0;
    got_cnt = -1;
    got_ovf = -1;
    lat     = -1;
    busy_n  = 0;
    @(negedge clk);
    s     = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < G + 20 && !seen; i++) begin
      if (which ? busy_b : busy_a) busy_n++;
      if (which ? done_b : done_a) begin
        seen    = 1'b1;
        lat     = cyc - s;
        got_cnt = which ? int'(count_b) : int'(count_a);
        got_ovf = which ? int'(ovf_b) : int'(ovf_a);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    bit which;
    int half;
    bit hold;
    int gap;
    int exp_cnt;  // -1: take from the rise-time model
    int exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, ov, lat, bsy, s, exp_c, exp_o, m, mx, dones;

    vecs[0] = '{which: 0, half: 5,  hold: 0, gap: 12, exp_cnt: 10, exp_ovf: 0};
    vecs[1] = '{which: 0, half: 0,  hold: 0, gap: 12, exp_cnt: 0,  exp_ovf: 0};
    vecs[2] = '{which: 0, half: 0,  hold: 1, gap: 12, exp_cnt: 0,  exp_ovf: 0};
    vecs[3] = '{which: 1, half: 2,  hold: 0, gap: 12, exp_cnt: 15, exp_ovf: 1};
    vecs[4] = '{which: 1, half: 5,  hold: 0, gap: 12, exp_cnt: 10, exp_ovf: 0};
    vecs[5] = '{which: 0, half: 5,  hold: 0, gap: 12, exp_cnt: 10, exp_ovf: 0};
    vecs[6] = '{which: 0, half: 10, hold: 0, gap: 0,  exp_cnt: -1, exp_ovf: -1};
    vecs[7] = '{which: 0, half: 4,  hold: 0, gap: 0,  exp_cnt: -1, exp_ovf: -1};

    #1;
    check("reset count", 32'(count_a), 0);
    check("reset ovf", 32'(ovf_a), 0);
    check("reset busy", 32'(busy_a), 0);
    check("reset done", 32'(done_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    half_b = 5;

    foreach (vecs[i]) begin
      if (vecs[i].which) begin
        half_b = vecs[i].half;
        hold_b = vecs[i].hold;
      end else begin
        half_a = vecs[i].half;
        hold_a = vecs[i].hold;
      end
      repeat (vecs[i].gap) @(negedge clk);
      measure(vecs[i].which, cnt, ov, lat, bsy, s);
      mx = vecs[i].which ? 15 : 65535;
      m  = model_count(vecs[i].which, s);
      exp_c = (vecs[i].exp_cnt >= 0) ? vecs[i].exp_cnt : ((m > mx) ? mx : m);
      exp_o = (vecs[i].exp_ovf >= 0) ? vecs[i].exp_ovf : ((m > mx) ? 1 : 0);
      check($sformatf("vec%0d count", i), cnt, exp_c);
      check($sformatf("vec%0d ovf", i), ov, exp_o);
      check($sformatf("vec%0d latency", i), lat, G + 1);
      check($sformatf("vec%0d busy cycles", i), bsy, G);
    end

    // start re-pulsed at gate cycles 3 and 50 and in the DONE cycle
    half_a = 5;
    repeat (12) @(negedge clk);
    s     = cyc;
    start = 1'b1;
    dones = 0;
    for (int k = 1; k <= G + 40; k++) begin
      @(negedge clk);
      start = (k == 4 || k == 51 || k == G + 1);
      if (done_a) dones++;
    end
    start = 1'b0;
    check("ignored starts: done pulses", dones, 1);
    check("ignored starts: busy after", 32'(busy_a), 0);
    check("ignored starts: count", 32'(count_a), 10);

    // reset during gate cycle 40
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset count", 32'(count_a), 0);
    check("mid reset ovf", 32'(ovf_a), 0);
    check("mid reset busy", 32'(busy_a), 0);
    check("mid reset done", 32'(done_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < G + 20; k++) begin
      @(negedge clk);
      if (done_a || busy_a) dones++;
    end
    check("after reset: no done/busy", dones, 0);
    measure(1'b0, cnt, ov, lat, bsy, s);
    check("after reset count", cnt, 10);
    check("after reset ovf", ov, 0);
    check("after reset latency", lat, G + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
